// File: rtl/alu_pkg.sv
// Shared opcode set, default sizing and decode helpers for the execute datapath.
package alu_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_GPR_AW = 4;

    typedef enum logic [3:0] {
        OP_ADD_A   = 4'h0,
        OP_MOV_A_B = 4'h1,
        OP_IN_A    = 4'h2,
        OP_MOV_A   = 4'h3,
        OP_MOV_B_A = 4'h4,
        OP_ADD_B   = 4'h5,
        OP_IN_B    = 4'h6,
        OP_MOV_B   = 4'h7,
        OP_OUT_B   = 4'h8,
        OP_OUT_IMM = 4'h9,
        OP_ST      = 4'hA,
        OP_LD      = 4'hB,
        OP_SUB_A   = 4'hC,
        OP_CMP_A   = 4'hD,
        OP_NOP_E   = 4'hE,
        OP_NOP_F   = 4'hF
    } opcode_t;

    // Ops whose adder result updates the carry/zero flags.
    function automatic logic is_flag_op(input opcode_t op);
        return op inside {OP_ADD_A, OP_MOV_A_B, OP_IN_A, OP_MOV_B_A,
                          OP_ADD_B, OP_IN_B, OP_SUB_A, OP_CMP_A};
    endfunction

    // Ops that consume the external input port.
    function automatic logic is_in_op(input opcode_t op);
        return op inside {OP_IN_A, OP_IN_B};
    endfunction

endpackage

// File: rtl/alu_core_p_if.sv
// Instruction, input-port and output-port handshake bundle of the execute stage.
interface alu_core_p_if #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W
);
    logic              instr_valid;
    logic [DATA_W+3:0] D_BUS;
    logic [DATA_W-1:0] in_port;
    logic              in_valid;
    logic              in_ready;
    logic              stall;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;

    // Upstream / environment side: drives instructions and input data.
    modport master (
        output instr_valid, D_BUS, in_port, in_valid,
        input  in_ready, stall, out_port, out_valid
    );

    // Execute stage side.
    modport slave (
        input  instr_valid, D_BUS, in_port, in_valid,
        output in_ready, stall, out_port, out_valid
    );
endinterface

// File: rtl/alu_core_p_gpr_file.sv
// General-purpose register file: synchronous reset and write, asynchronous read.
module gpr_file #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W,
    parameter int GPR_AW = alu_pkg::DEF_GPR_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [GPR_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [GPR_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << GPR_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every entry on reset, otherwise write one entry when enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_core_p.sv
// Execute datapath: instruction decode, shared adder, A/B/out registers and flags.
module alu_core_p
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int GPR_AW = DEF_GPR_AW
) (
    input  logic              clock,
    input  logic              reset,
    alu_core_p_if.slave       bus,
    output logic              cflag,
    output logic              zflag,
    output logic [DATA_W-1:0] A_reg_out,
    output logic [DATA_W-1:0] B_reg_out
);
    opcode_t           op;
    logic [DATA_W-1:0] imm;
    logic              fire;
    logic              in_op;

    logic [DATA_W-1:0] a_q, b_q, out_q;
    logic              c_q, z_q, ov_q;

    logic [DATA_W-1:0] add_x, add_y;
    logic              add_sub;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic              c_new;

    logic              gpr_we;
    logic [GPR_AW-1:0] gpr_addr;
    logic [DATA_W-1:0] gpr_rdata;

    assign op    = opcode_t'(bus.D_BUS[DATA_W+3:DATA_W]);
    assign imm   = bus.D_BUS[DATA_W-1:0];
    assign in_op = is_in_op(op);

    assign bus.stall    = bus.instr_valid && in_op && !bus.in_valid;
    assign fire         = bus.instr_valid && !bus.stall;
    assign bus.in_ready = fire && in_op;

    // Select adder operands; subtract/compare use A + ~imm + 1.
    always_comb begin
        add_x   = '0;
        add_y   = imm;
        add_sub = 1'b0;
        case (op)
            OP_ADD_A, OP_MOV_B_A:          add_x = a_q;
            OP_MOV_A_B, OP_ADD_B, OP_OUT_B: add_x = b_q;
            OP_IN_A, OP_IN_B:              add_x = bus.in_port;
            OP_SUB_A, OP_CMP_A: begin
                add_x   = a_q;
                add_y   = ~imm;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_sub};
    assign result = sum[DATA_W-1:0];
    // Carry-out of the subtract form is the inverse of borrow.
    assign c_new  = add_sub ? ~sum[DATA_W] : sum[DATA_W];

    assign gpr_we   = fire && (op == OP_ST);
    assign gpr_addr = imm[GPR_AW-1:0];

    gpr_file #(
        .DATA_W(DATA_W),
        .GPR_AW(GPR_AW)
    ) u_gpr (
        .clock (clock),
        .reset (reset),
        .we    (gpr_we),
        .waddr (gpr_addr),
        .wdata (b_q),
        .raddr (gpr_addr),
        .rdata (gpr_rdata)
    );

    // Architectural register update for the fired instruction; reset has priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            if (fire) begin
                case (op)
                    OP_ADD_A, OP_MOV_A_B, OP_IN_A, OP_SUB_A: a_q <= result;
                    OP_MOV_A:                                a_q <= imm;
                    OP_MOV_B_A, OP_ADD_B, OP_IN_B:           b_q <= result;
                    OP_MOV_B:                                b_q <= imm;
                    OP_LD:                                   b_q <= gpr_rdata;
                    OP_OUT_B: begin
                        out_q <= result;
                        ov_q  <= 1'b1;
                    end
                    OP_OUT_IMM: begin
                        out_q <= imm;
                        ov_q  <= 1'b1;
                    end
                    default: ;
                endcase
                if (is_flag_op(op)) begin
                    c_q <= c_new;
                    z_q <= (result == '0);
                end
            end
        end
    end

    assign A_reg_out     = a_q;
    assign B_reg_out     = b_q;
    assign bus.out_port  = out_q;
    assign bus.out_valid = ov_q;
    assign cflag         = c_q;
    assign zflag         = z_q;

endmodule

// File: doc/alu_core_p.md
# alu_core_p

Parametrised next-generation execute datapath for the pipelined CPU's execute stage. It decodes one instruction word per cycle from `D_BUS` and updates the A, B and output registers, a general-purpose register file, and registered carry/zero flags. Relative to the fixed 4-bit execute block it adds:
- parametrised data width and GPR depth;
- subtract and compare operations;
- a real flag register;
- valid/ready handshakes on the instruction, input-port and output-port paths.

It sits between the fetch/decode stage, which drives `D_BUS`, and the I/O ports.

## Interface
- `DATA_W`, 4: datapath and immediate width.
- `GPR_AW`, 4: GPR address width. Depth is 2**`GPR_AW`. Requires `GPR_AW` <= `DATA_W`.
- `clock` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `instr_valid` in 1: `D_BUS` holds an instruction this cycle.
- `D_BUS` in `DATA_W`+4: opcode = `[DATA_W+3:DATA_W]`, imm = `[DATA_W-1:0]`.
- `in_port` in `DATA_W`: external input data.
- `in_valid` in 1: `in_port` is valid.
- `in_ready` out 1: comb. High when an IN op consumes `in_port` this cycle.
- `stall` out 1: comb. High when an IN op is waiting for `in_valid`.
- `cflag` out 1: registered carry/borrow flag.
- `zflag` out 1: registered zero flag.
- `A_reg_out` out `DATA_W`: A register.
- `B_reg_out` out `DATA_W`: B register.
- `out_port` out `DATA_W`: output register.
- `out_valid` out 1: registered one-cycle pulse following each OUT op.

## Operation
- `fire` = `instr_valid` && !`stall`. No architectural state changes unless `fire`.
- `stall` = `instr_valid` && (op is IN A or IN B) && !`in_valid`.
- `in_ready` = `fire` && (op is IN A or IN B).
- Opcodes:
  - 0x0 ADD A,imm: A <= A+imm.
  - 0x1 MOV A,B+imm: A <= B+imm.
  - 0x2 IN A: A <= in+imm.
  - 0x3 MOV A,imm: A <= imm.
  - 0x4 MOV B,A+imm: B <= A+imm.
  - 0x5 ADD B,imm: B <= B+imm.
  - 0x6 IN B: B <= in+imm.
  - 0x7 MOV B,imm: B <= imm.
  - 0x8 OUT B+imm: out <= B+imm.
  - 0x9 OUT imm: out <= imm.
  - 0xA ST: GPR[imm[GPR_AW-1:0]] <= B.
  - 0xB LD: B <= GPR[imm[GPR_AW-1:0]].
  - 0xC SUB A,imm: A <= A-imm.
  - 0xD CMP A,imm: computes A-imm, updates flags only.
  - 0xE, 0xF: NOP. Reserved for the branch unit; no effect here.
- Arithmetic uses a `DATA_W`+1-bit adder.
  - Sums wrap modulo 2**`DATA_W`.
  - For add ops, carry = sum bit `DATA_W`.
  - SUB/CMP compute A + ~imm + 1. `cflag` = borrow = NOT carry-out, i.e. 1 iff A < imm (unsigned).
- Flag update set is ops 0x0, 0x1, 0x2, 0x4, 0x5, 0x6, 0xC, 0xD, on `fire` only.
  - `cflag` <= carry/borrow; `zflag` <= (result == 0).
  - All other ops and non-fire cycles hold both flags.
- `out_valid` <= `fire` && op in {0x8, 0x9}; otherwise 0.
- `out_port` holds its value until the next OUT op.
- Reset (synchronous, priority over `fire`) zeros all of the following:
  - A, B, `out_port`;
  - `cflag`, `zflag`, `out_valid`;
  - every GPR entry.

## Timing
- Latency is one cycle. A fired op's result appears on the register outputs after the next rising edge.
- `stall` and `in_ready` are combinational from `instr_valid`, `D_BUS` and `in_valid`. There are no paths from them back into those inputs.
- Back-to-back dependencies resolve with no bubbles, since every op reads current register values:
  - ST then LD to the same address returns the stored value;
  - MOV B then ST stores the new B.
- The GPR read is asynchronous and the write is synchronous. LD while `stall` cannot occur, because only IN ops stall.
- Held stall: the instruction is held by upstream. Once `in_valid` rises, that same cycle fires, with exactly one `in_ready` pulse.
- Reset asserted with `instr_valid` high: reset wins, the instruction is dropped, and outputs read zero after the edge.

## Structure
- Package `alu_pkg` holds:
  - the opcode localparams (`OP_ADD_A` … `OP_NOP_F`);
  - default `DATA_W`/`GPR_AW`;
  - a function `is_flag_op(op)`.
- Sub-module `gpr_file`: parameters `DATA_W`, `GPR_AW`; ports `clock`, `reset`, `we`, `waddr`, `wdata`, `raddr`, `rdata`. It has a synchronous-reset array, a synchronous write and a combinational read.
- The top level holds the decode, the adder and the A/B/out/flag registers.

## Test plan
- Reset: hold `reset` for 2 cycles with random `D_BUS` → all outputs are 0. LD from every address → B = 0.
- Carry and zero: MOV A,0xF; ADD A,0x1 (`DATA_W`=4) → A = 0x0, `cflag` = 1, `zflag` = 1. Then MOV A,0x2 → flags unchanged.
- Subtract and compare: MOV A,0x3; SUB A,0x5 → A = 0xE, `cflag` = 1, `zflag` = 0. Then CMP A,0xE → A = 0xE, `cflag` = 0, `zflag` = 1.
- Input handshake: IN A with imm 0x1 and `in_valid` = 0 for 3 cycles → `stall` = 1, `in_ready` = 0, A unchanged. Then `in_valid` = 1, `in_port` = 0x6 → `in_ready` pulses for 1 cycle, and A = 0x7 next cycle.
- GPR: MOV B,0x9; ST R5; MOV B,0x0; LD R5 → B = 0x9. Then LD R6 → B = 0x0.
- Output: OUT imm 0xA → `out_port` = 0xA, `out_valid` high for exactly 1 cycle. Reset in the cycle of an OUT B+imm with `instr_valid` = 1 → `out_port` = 0, `out_valid` = 0.
